uart_receiver: RTL and testbench
================================

# uart_receiver

Serial-to-parallel receive side of the UART link, the counterpart of the UART transmitter. Samples an asynchronous `rx_in` line: 8N1 framing, LSB first, idle-high. Each data bit is sampled at its centre using the same `clock_per_bit` timing as the transmitter. Delivers each received byte with a one-cycle `rx_done` strobe, and flags frames whose stop bit is low.

## Interface
- `clock_per_bit`, 50: clk cycles per bit (clk frequency / baud rate); legal range 4..255.
- `clk`  in  1  system clock; all logic on posedge.
- `rst_n`  in  1  synchronous, active-low reset.
- `rx_in`  in  1  asynchronous serial line, idle high.
- `rx_data_out`  out  8  last correctly framed byte; held until the next good frame.
- `rx_done`  out  1  one-cycle pulse when `rx_data_out` is updated.
- `rx_ongoing`  out  1  high from start-bit detect until return to idle.
- `rx_frame_err`  out  1  one-cycle pulse when the stop bit samples low.

## Operation
- `rx_in` passes through a 2-flop synchronizer (`sync1`, `sync2`); both flops reset to 1. All decisions use `sync2`.
- Half-bit constant: H = (clock_per_bit-1)/2, integer division (24 at default).
- `clock_count` is 8 bits; `bit_index` is 3 bits.
- Reset: state=IDLE, counters 0, `rx_data_out`=0x00, `rx_done`=0, `rx_ongoing`=0, `rx_frame_err`=0. Reset mid-frame drops the partial byte with no strobe.
- IDLE: `clock_count`=0, `bit_index`=0. If `sync2`==0: go to START and set `rx_ongoing`=1.
- START: if `clock_count` < H, increment. Otherwise:
  - `sync2`==0: valid start; go to DATA, `clock_count`=0.
  - `sync2`==1: glitch; go to IDLE, `rx_ongoing`=0, no strobe.
- DATA: if `clock_count` < clock_per_bit-1, increment. Otherwise:
  - sample `sync2` into shift register bit [`bit_index`] and set `clock_count`=0.
  - if `bit_index`==7: go to STOP, `bit_index`=0; else increment `bit_index`.
- STOP: if `clock_count` < clock_per_bit-1, increment. Otherwise:
  - `sync2`==1: `rx_data_out`←shift register, `rx_done`=1.
  - `sync2`==0: `rx_frame_err`=1; `rx_data_out` unchanged.
  - Either way go to CLEANUP, `clock_count`=0.
- CLEANUP: `rx_done`=0, `rx_frame_err`=0, `rx_ongoing`=0, go to IDLE.
- Illegal state encodings go to IDLE.
- A low line seen in IDLE after CLEANUP starts a new frame, so back-to-back frames with one stop bit are received without loss.
- A permanently low line produces repeated framing errors, one per frame time. No lockup.

## Timing
- Reference point: E0, the clk edge at which `sync1` first captures `rx_in` low. `sync2` goes low at E1; state becomes START at E2.
- Start validated at E(3+H). Data bit k is sampled at E(3+H+(k+1)·clock_per_bit).
- Stop is sampled at E(3+H+9·clock_per_bit). `rx_done`/`rx_frame_err` are high for exactly the following cycle: 477 edges after E0 at default.
- `rx_ongoing` rises after E2 and falls after the CLEANUP edge.
- `rx_done` and `rx_frame_err` are never high together, and never high for more than 1 cycle.

## Structure
- Shared package `uart_pkg`, used by both transmitter and receiver:
  - state encodings: IDLE=000, START=001, DATA=010, STOP=011, CLEANUP=100;
  - default `clock_per_bit`=50;
  - frame width of 8 data bits.
- One sub-module: `uart_rx_sync`, a 2-flop synchronizer with reset value 1, parameterless.

## Test plan
- Transmitter→receiver loopback at default parameter: send 0xA5, then 0x3C → `rx_data_out`=0xA5, then 0x3C. Each `rx_done` fires 477 edges after E0; `rx_frame_err` never asserts.
- Back-to-back 0x00, 0xFF, 0x80 with no idle gap → three `rx_done` pulses carrying the exact bytes in order.
- 10-cycle low pulse on idle line → START aborts at E(3+H); no `rx_done`; `rx_ongoing` low again after 28 cycles; `rx_data_out` unchanged.
- Frame 0x55 with stop bit forced low → single `rx_frame_err` pulse; `rx_data_out` keeps the previous value.
- `rst_n`=0 for 1 cycle during data bit 4 of 0x96 → all outputs 0 on the next cycle. A following clean 0x96 frame is received correctly.
- `clock_per_bit`=4 (H=1): loopback 0xC3 → received correctly, `rx_done` 3+1+36=40 edges after E0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encodings, default
// bit timing and frame width.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'b000,
        START   = 3'b001,
        DATA    = 3'b010,
        STOP    = 3'b011,
        CLEANUP = 3'b100
    } uart_state_t;

    // clk cycles per serial bit (clk frequency / baud rate)
    localparam int CLOCK_PER_BIT = 50;

    // data bits per frame
    localparam int FRAME_BITS = 8;

    // Cycles from start-bit detect to the start-bit centre, truncated.
    function automatic logic [7:0] half_bit(input int cpb);
        return 8'((cpb - 1) / 2);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line. Both flops come
// out of reset high so an idle line is never mistaken for a start bit.
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic rx_in,
    output logic rx_sync
);

    logic sync1;
    logic sync2;

    // Shift the raw line through two flops to settle metastability
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= rx_in;
            sync2 <= sync1;
        end
    end

    assign rx_sync = sync2;

endmodule

// File: rtl/uart_receiver.sv
// UART receiver, 8N1, LSB first. Detects the start bit, re-aligns to its
// centre and then samples every data bit and the stop bit at bit centre.
// A good frame updates rx_data_out with a one-cycle rx_done strobe; a low
// stop bit gives a one-cycle rx_frame_err and leaves rx_data_out alone.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int clock_per_bit = CLOCK_PER_BIT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_in,
    output logic [7:0] rx_data_out,
    output logic       rx_done,
    output logic       rx_ongoing,
    output logic       rx_frame_err
);

    localparam logic [7:0] LAST_COUNT = 8'(clock_per_bit - 1);
    localparam logic [7:0] HALF_COUNT = half_bit(clock_per_bit);
    localparam logic [2:0] LAST_INDEX = 3'(FRAME_BITS - 1);

    logic        rx_sync;

    uart_state_t state_reg,    state_next;
    logic [7:0]  count_reg,    count_next;
    logic [2:0]  index_reg,    index_next;
    logic [7:0]  shift_reg,    shift_next;
    logic [7:0]  data_reg,     data_next;
    logic        done_reg,     done_next;
    logic        err_reg,      err_next;
    logic        ongoing_reg,  ongoing_next;

    uart_rx_sync u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .rx_in   (rx_in),
        .rx_sync (rx_sync)
    );

    // State and datapath registers; reset discards any partial frame
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            count_reg   <= 8'd0;
            index_reg   <= 3'd0;
            shift_reg   <= 8'd0;
            data_reg    <= 8'd0;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
            ongoing_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            count_reg   <= count_next;
            index_reg   <= index_next;
            shift_reg   <= shift_next;
            data_reg    <= data_next;
            done_reg    <= done_next;
            err_reg     <= err_next;
            ongoing_reg <= ongoing_next;
        end
    end

    // Next-state and datapath decode; strobes default low so they last one cycle
    always_comb begin
        state_next   = state_reg;
        count_next   = count_reg;
        index_next   = index_reg;
        shift_next   = shift_reg;
        data_next    = data_reg;
        done_next    = 1'b0;
        err_next     = 1'b0;
        ongoing_next = ongoing_reg;

        case (state_reg)
            IDLE: begin
                count_next = 8'd0;
                index_next = 3'd0;
                if (!rx_sync) begin
                    state_next   = START;
                    ongoing_next = 1'b1;
                end
            end
            START: begin
                if (count_reg < HALF_COUNT) begin
                    count_next = count_reg + 8'd1;
                end else if (!rx_sync) begin
                    state_next = DATA;
                    count_next = 8'd0;
                end else begin
                    // line went back high before the start-bit centre: glitch
                    state_next   = IDLE;
                    ongoing_next = 1'b0;
                end
            end
            DATA: begin
                if (count_reg < LAST_COUNT) begin
                    count_next = count_reg + 8'd1;
                end else begin
                    shift_next[index_reg] = rx_sync;
                    count_next            = 8'd0;
                    if (index_reg == LAST_INDEX) begin
                        state_next = STOP;
                        index_next = 3'd0;
                    end else begin
                        index_next = index_reg + 3'd1;
                    end
                end
            end
            STOP: begin
                if (count_reg < LAST_COUNT) begin
                    count_next = count_reg + 8'd1;
                end else begin
                    if (rx_sync) begin
                        data_next = shift_reg;
                        done_next = 1'b1;
                    end else begin
                        err_next = 1'b1;
                    end
                    state_next = CLEANUP;
                    count_next = 8'd0;
                end
            end
            CLEANUP: begin
                ongoing_next = 1'b0;
                state_next   = IDLE;
            end
            default: begin
                state_next   = IDLE;
                count_next   = 8'd0;
                index_next   = 3'd0;
                ongoing_next = 1'b0;
            end
        endcase
    end

    assign rx_data_out  = data_reg;
    assign rx_done      = done_reg;
    assign rx_frame_err = err_reg;
    assign rx_ongoing   = ongoing_reg;

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: one instance at the default 50 clocks/bit and one
// at 4 clocks/bit. Frames are driven bit by bit; each expected strobe (kind,
// byte, arrival cycle) is queued at stimulus time and checked by monitors.
module tb_uart_receiver;

    typedef struct {
        logic       err;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_a = 1'b1;
    logic       rx_b = 1'b1;
    logic [7:0] data_a, data_b;
    logic       done_a, done_b;
    logic       ongoing_a, ongoing_b;
    logic       err_a, err_b;

    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    logic [7:0] last_good_a = 8'h00;
    logic [7:0] last_good_b = 8'h00;

    uart_receiver dut_a (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_in        (rx_a),
        .rx_data_out  (data_a),
        .rx_done      (done_a),
        .rx_ongoing   (ongoing_a),
        .rx_frame_err (err_a)
    );

    uart_receiver #(.clock_per_bit(4)) dut_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_in        (rx_b),
        .rx_data_out  (data_b),
        .rx_done      (done_b),
        .rx_ongoing   (ongoing_b),
        .rx_frame_err (err_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Drive one 8N1 frame starting just after a posedge; lat = edges from E0 to strobe
    task automatic send_frame(input int which, input logic [7:0] d, input logic stop_bit,
                              input int lat);
        exp_t e;
        int   cpb;
        logic [9:0] bits;
        cpb   = (which == 0) ? 50 : 4;
        bits  = {stop_bit, d, 1'b0};
        e.err = ~stop_bit;
        e.cyc = cyc + 1 + lat;
        if (which == 0) begin
            if (stop_bit) last_good_a = d;
            e.data = last_good_a;
            q_a.push_back(e);
        end else begin
            if (stop_bit) last_good_b = d;
            e.data = last_good_b;
            q_b.push_back(e);
        end
        $display("[TB] send dut%0d byte 0x%02h stop=%0b expect strobe at cycle %0d",
                 which, d, stop_bit, e.cyc);
        for (int i = 0; i < 10; i++) begin
            if (which == 0) rx_a = bits[i];
            else            rx_b = bits[i];
            repeat (cpb) @(posedge clk);
            #1;
        end
        rx_a = 1'b1;
        rx_b = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor for the default-rate instance
    always @(negedge clk) begin
        if (done_a || err_a) begin
            if (q_a.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_strobe_a: done=%0b err=%0b data=0x%02h, expected none (cycle %0d)",
                         done_a, err_a, data_a, cyc);
            end else begin
                exp_t e;
                e = q_a.pop_front();
                check("strobe_done_a", {31'd0, done_a}, {31'd0, ~e.err});
                check("strobe_err_a",  {31'd0, err_a},  {31'd0, e.err});
                check("strobe_data_a", {24'd0, data_a}, {24'd0, e.data});
                check("strobe_cycle_a", cyc, e.cyc);
                $display("[TB] dut0 strobe done=%0b err=%0b data=0x%02h at cycle %0d",
                         done_a, err_a, data_a, cyc);
            end
        end
    end

    // Monitor for the 4-clocks-per-bit instance
    always @(negedge clk) begin
        if (done_b || err_b) begin
            if (q_b.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_strobe_b: done=%0b err=%0b data=0x%02h, expected none (cycle %0d)",
                         done_b, err_b, data_b, cyc);
            end else begin
                exp_t e;
                e = q_b.pop_front();
                check("strobe_done_b", {31'd0, done_b}, {31'd0, ~e.err});
                check("strobe_err_b",  {31'd0, err_b},  {31'd0, e.err});
                check("strobe_data_b", {24'd0, data_b}, {24'd0, e.data});
                check("strobe_cycle_b", cyc, e.cyc);
                $display("[TB] dut1 strobe done=%0b err=%0b data=0x%02h at cycle %0d",
                         done_b, err_b, data_b, cyc);
            end
        end
    end

    initial begin
        int n;

        // Reset state
        idle(3);
        check("reset_data",    {24'd0, data_a}, 32'h00);
        check("reset_done",    {31'd0, done_a}, 32'h0);
        check("reset_ongoing", {31'd0, ongoing_a}, 32'h0);
        check("reset_err",     {31'd0, err_a}, 32'h0);
        rst_n = 1'b1;
        idle(5);

        // Loopback-style frames with idle gaps
        send_frame(0, 8'hA5, 1'b1, 477);
        idle(20);
        send_frame(0, 8'h3C, 1'b1, 477);
        idle(20);
        check("hold_after_3c", {24'd0, data_a}, 32'h3C);

        // Back-to-back frames, one stop bit, no idle gap
        send_frame(0, 8'h00, 1'b1, 477);
        send_frame(0, 8'hFF, 1'b1, 477);
        send_frame(0, 8'h80, 1'b1, 477);
        idle(20);

        // 10-cycle glitch: start aborts at E27, no strobe
        n = cyc;
        rx_a = 1'b0;
        idle(10);
        rx_a = 1'b1;
        idle(17);
        check("glitch_ongoing_e26", {31'd0, ongoing_a}, 32'h1);
        idle(1);
        check("glitch_ongoing_e27", {31'd0, ongoing_a}, 32'h0);
        check("glitch_cycle", cyc, n + 28);
        check("glitch_data_kept", {24'd0, data_a}, 32'h80);
        idle(40);

        // Stop bit forced low: one frame error, data keeps 0x80
        send_frame(0, 8'h55, 1'b0, 477);
        idle(100);
        check("frame_err_data_kept", {24'd0, data_a}, 32'h80);

        // Reset for one cycle during data bit 4 of 0x96; line returns idle
        rx_a = 1'b0;
        idle(50);
        for (int i = 0; i < 4; i++) begin
            rx_a = (8'h96 >> i) & 8'h01;
            idle(50);
        end
        rx_a = 1'b1;               // bit 4 of 0x96 is 1
        idle(25);
        check("mid_frame_ongoing", {31'd0, ongoing_a}, 32'h1);
        rst_n = 1'b0;
        idle(1);
        check("midreset_data",    {24'd0, data_a}, 32'h00);
        check("midreset_done",    {31'd0, done_a}, 32'h0);
        check("midreset_ongoing", {31'd0, ongoing_a}, 32'h0);
        check("midreset_err",     {31'd0, err_a}, 32'h0);
        rst_n = 1'b1;
        last_good_a = 8'h00;
        last_good_b = 8'h00;
        idle(10);
        send_frame(0, 8'h96, 1'b1, 477);
        idle(20);

        // Minimum bit time: 4 clocks per bit, H = 1
        send_frame(1, 8'hC3, 1'b1, 40);
        idle(20);
        check("min_cpb_data", {24'd0, data_b}, 32'hC3);

        // Every queued strobe must have arrived (bounded wait)
        for (int i = 0; i < 600 && (q_a.size() != 0 || q_b.size() != 0); i++)
            @(posedge clk);
        check("queue_a_drained", q_a.size(), 32'd0);
        check("queue_b_drained", q_b.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
